// File: rtl/split_n_dispatch.sv
// Routes one four-phase req/ack transaction to one of NCH channels chosen by opcode lookup.
// Optional ack timeout is compiled in with `define SPLIT_TIMEOUT_EN.
module split_n_dispatch #(
    parameter int                 NCH        = 2,
    parameter int                 OPW        = 7,
    parameter logic [NCH*OPW-1:0] CH_OPCODES = {7'b0000011, 7'b0100011},
    parameter int                 TO_W       = 8,
    localparam int                SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   opcode,
    input  logic             req_in,
    output logic             ack_out,
    output logic [NCH-1:0]   req_out,
    input  logic [NCH-1:0]   ack_in,
    output logic [SEL_W-1:0] sel_ch,
    output logic             busy,
    output logic             err_opcode,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_REQ,
        S_ACKD,
        S_REL,
        S_ERR
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [NCH-1:0]   r_req_out, w_req_out_nxt;
    logic             r_ack_out, w_ack_out_nxt;
    logic             r_err_op, w_err_op_nxt;
    logic             r_err_to, w_err_to_nxt;
    logic             r_busy;

    logic             w_hit;
    logic [SEL_W-1:0] w_hit_ch;
    logic [NCH-1:0]   w_onehot;
    logic             w_ack_sel;
    logic             w_to_expire;

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (opcode == CH_OPCODES[i*OPW +: OPW]) begin
                w_hit    = 1'b1;
                w_hit_ch = SEL_W'(i);
            end
        end
    end

    assign w_onehot  = NCH'(1) << w_hit_ch;
    assign w_ack_sel = ack_in[r_sel];

`ifdef SPLIT_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_inc;

    assign w_to_cnt_inc = r_to_cnt + TO_W'(1);
    assign w_to_expire  = &w_to_cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((w_state_nxt == S_REQ || w_state_nxt == S_REL) && w_state_nxt != r_state) begin
            r_to_cnt <= '0;
        end else if (r_state == S_REQ || r_state == S_REL) begin
            r_to_cnt <= w_to_cnt_inc;
        end
    end
`else
    assign w_to_expire = 1'b0;
`endif

    // NOTE: every next value defaults to its own register, so no path through the case infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_req_out_nxt = r_req_out;
        w_ack_out_nxt = r_ack_out;
        w_err_op_nxt  = r_err_op;
        w_err_to_nxt  = r_err_to;
        case (r_state)
            S_SYNC: begin
                if (!req_in) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (req_in) begin
                    w_err_op_nxt = 1'b0;
                    w_err_to_nxt = 1'b0;
                    if (w_hit) begin
                        w_sel_nxt     = w_hit_ch;
                        w_req_out_nxt = w_onehot;
                        w_state_nxt   = S_REQ;
                    end else begin
                        w_err_op_nxt  = 1'b1;
                        w_ack_out_nxt = 1'b1;
                        w_state_nxt   = S_ERR;
                    end
                end
            end
            S_REQ: begin
                if (w_ack_sel) begin
                    w_ack_out_nxt = 1'b1;
                    w_state_nxt   = S_ACKD;
                end else if (w_to_expire) begin
                    w_req_out_nxt = '0;
                    w_ack_out_nxt = 1'b1;
                    w_err_to_nxt  = 1'b1;
                    w_state_nxt   = S_ERR;
                end
            end
            S_ACKD: begin
                if (!req_in) begin
                    w_req_out_nxt = '0;
                    w_state_nxt   = S_REL;
                end
            end
            S_REL: begin
                if (!w_ack_sel) begin
                    w_ack_out_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else if (w_to_expire) begin
                    w_ack_out_nxt = 1'b1;
                    w_err_to_nxt  = 1'b1;
                    w_state_nxt   = S_ERR;
                end
            end
            S_ERR: begin
                if (!req_in) begin
                    w_ack_out_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_SYNC;
            r_sel     <= '0;
            r_req_out <= '0;
            r_ack_out <= 1'b0;
            r_err_op  <= 1'b0;
            r_err_to  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_req_out <= w_req_out_nxt;
            r_ack_out <= w_ack_out_nxt;
            r_err_op  <= w_err_op_nxt;
            r_err_to  <= w_err_to_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign ack_out     = r_ack_out;
    assign req_out     = r_req_out;
    assign sel_ch      = r_sel;
    assign busy        = r_busy;
    assign err_opcode  = r_err_op;
    assign err_timeout = r_err_to;

    // Sender must hold req_in until the selected channel acks.
    a_req_held: assert property (@(posedge clk) disable iff (rst) (r_state == S_REQ) |-> req_in);

endmodule

// File: tb/tb_split_n_dispatch.sv
// Directed vector bench for split_n_dispatch with default two-channel table (ch1=load, ch0=store).
module tb_split_n_dispatch;

    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_BAD = 7'b0110011;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       req_in;
    logic       ack_out;
    logic [1:0] req_out;
    logic [1:0] ack_in;
    logic [0:0] sel_ch;
    logic       busy;
    logic       err_opcode;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;

    split_n_dispatch dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .req_in      (req_in),
        .ack_out     (ack_out),
        .req_out     (req_out),
        .ack_in      (ack_in),
        .sel_ch      (sel_ch),
        .busy        (busy),
        .err_opcode  (err_opcode),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {ack_out, req_out[1:0], sel_ch, busy, err_opcode, err_timeout}
    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       req;
        logic [1:0] ack;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [6:0] op, input logic rq,
                                input logic [1:0] ak, input logic e_ack, input logic [1:0] e_req,
                                input logic e_sel, input logic e_busy, input logic e_eop);
        vec_t v;
        v.rst = r;
        v.op  = op;
        v.req = rq;
        v.ack = ak;
        v.exp = {e_ack, e_req, e_sel, e_busy, e_eop, 1'b0};
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {ack_out, req_out, sel_ch, busy, err_opcode, err_timeout};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst    = 1'b1;
        opcode = '0;
        req_in = 1'b0;
        ack_in = '0;

        //                r  op      rq ack    ack req   sel bsy eop
        vecs.push_back(mk(1, 7'd0,   0, 2'b00, 0, 2'b00, 0, 0, 0)); // reset
        vecs.push_back(mk(0, 7'd0,   0, 2'b00, 0, 2'b00, 0, 0, 0)); // SYNC->IDLE
        vecs.push_back(mk(0, OP_ST,  1, 2'b00, 0, 2'b01, 0, 1, 0)); // store accept
        vecs.push_back(mk(0, OP_ST,  1, 2'b00, 0, 2'b01, 0, 1, 0));
        vecs.push_back(mk(0, OP_ST,  1, 2'b10, 0, 2'b01, 0, 1, 0)); // foreign ack ignored
        vecs.push_back(mk(0, OP_ST,  1, 2'b01, 1, 2'b01, 0, 1, 0));
        vecs.push_back(mk(0, OP_ST,  0, 2'b01, 1, 2'b00, 0, 1, 0));
        vecs.push_back(mk(0, OP_ST,  0, 2'b00, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, OP_LD,  1, 2'b00, 0, 2'b10, 1, 1, 0)); // load
        vecs.push_back(mk(0, OP_LD,  1, 2'b10, 1, 2'b10, 1, 1, 0));
        vecs.push_back(mk(0, OP_LD,  0, 2'b10, 1, 2'b00, 1, 1, 0));
        vecs.push_back(mk(0, OP_LD,  0, 2'b00, 0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(0, OP_BAD, 1, 2'b00, 1, 2'b00, 1, 1, 1)); // bad opcode
        vecs.push_back(mk(0, OP_BAD, 1, 2'b11, 1, 2'b00, 1, 1, 1));
        vecs.push_back(mk(0, OP_BAD, 0, 2'b00, 0, 2'b00, 1, 0, 1)); // error held
        vecs.push_back(mk(0, OP_ST,  1, 2'b00, 0, 2'b01, 0, 1, 0)); // accept clears error
        vecs.push_back(mk(0, OP_ST,  1, 2'b01, 1, 2'b01, 0, 1, 0));
        vecs.push_back(mk(0, OP_ST,  0, 2'b11, 1, 2'b00, 0, 1, 0));
        vecs.push_back(mk(0, OP_ST,  0, 2'b10, 0, 2'b00, 0, 0, 0)); // REL ignores ack_in[1]
        vecs.push_back(mk(0, OP_LD,  1, 2'b00, 0, 2'b10, 1, 1, 0));
        vecs.push_back(mk(1, OP_LD,  1, 2'b00, 0, 2'b00, 0, 0, 0)); // reset in REQ
        vecs.push_back(mk(0, OP_LD,  1, 2'b00, 0, 2'b00, 0, 1, 0)); // SYNC holds
        vecs.push_back(mk(0, OP_LD,  1, 2'b10, 0, 2'b00, 0, 1, 0));
        vecs.push_back(mk(0, OP_LD,  0, 2'b00, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, OP_LD,  1, 2'b00, 0, 2'b10, 1, 1, 0)); // fresh request
        vecs.push_back(mk(0, OP_LD,  1, 2'b10, 1, 2'b10, 1, 1, 0));
        vecs.push_back(mk(0, OP_LD,  0, 2'b10, 1, 2'b00, 1, 1, 0));
        vecs.push_back(mk(0, OP_LD,  0, 2'b00, 0, 2'b00, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst    = vecs[i].rst;
            opcode = vecs[i].op;
            req_in = vecs[i].req;
            ack_in = vecs[i].ack;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Opcode and foreign ack changes are ignored once a store is in flight.
        opcode = OP_ST;
        req_in = 1'b1;
        ack_in = 2'b00;
        tick();
        check("hold_accept", 32'(outs()), 32'(7'b0_01_0_1_0_0));
        opcode = OP_BAD;
        ack_in = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_req%0d", i), 32'(outs()), 32'(7'b0_01_0_1_0_0));
        end

        // Ack latency is one clock from ack_in[sel_ch].
        ack_in = 2'b01;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ack_out && lat < 8);
        check("ack_latency", 32'(lat), 32'd1);

        req_in = 1'b0;
        tick();
        check("hold_rel", 32'(outs()), 32'(7'b1_00_0_1_0_0));
        ack_in = 2'b00;
        tick();
        check("hold_idle", 32'(outs()), 32'(7'b0_00_0_0_0_0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
